// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and parity helper for the UART encoder
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 50 MHz / 115200 baud; matches the decoder's 8680 ns bit period at a 20 ns clock
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - byte FIFO with wrap-bit pointers, occupancy and full/empty flags
module uart_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    wdata,
  input  logic          push,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]  mem [2**AW];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_encoder.sv
// rtl/uart_encoder.sv - buffered UART transmitter, idle-high, LSB first, optional parity
module uart_encoder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = PAR_NONE,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic          tx, tx_n;
  logic          pop, load, bit_end;
  logic [7:0]    fifo_q;
  logic          full, empty;

  uart_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wdata (data_i),
    .push  (valid_i),
    .pop   (pop),
    .rdata (fifo_q),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  assign ready_o = !full;
  assign tx_o    = tx;
  assign busy_o  = (state != ST_IDLE) || (level_o != '0);
  assign bit_end = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      par     <= par_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx;
    pop     = 1'b0;
    load    = 1'b0;
    if (state != ST_IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;
    case (state)
      ST_IDLE: load = !empty;
      ST_START: if (bit_end) begin
        state_n = ST_DATA;
        tx_n    = sh[0];
        sh_n    = sh >> 1;
        bit_n   = '0;
      end
      ST_DATA: if (bit_end) begin
        if (bit_cnt == 3'd7) begin
          bit_n = '0;
          if (PARITY != PAR_NONE) begin
            state_n = ST_PARITY;
            tx_n    = par;
          end else begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n = bit_cnt + 3'd1;
          tx_n  = sh[0];
          sh_n  = sh >> 1;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_n = ST_STOP;
        tx_n    = 1'b1;
        bit_n   = '0;
      end
      ST_STOP: if (bit_end) begin
        if (bit_cnt == STOP_LAST) begin
          // Next queued byte starts on this very edge: no idle gap between frames.
          load    = !empty;
          state_n = ST_IDLE;
          tx_n    = 1'b1;
        end else begin
          bit_n = bit_cnt + 3'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      sh_n    = fifo_q;
      par_n   = parity_bit(fifo_q, PARITY);
      tx_n    = 1'b0;
      cnt_n   = '0;
      bit_n   = '0;
      state_n = ST_START;
    end
  end

endmodule
